// File: rtl/passcode_checker_if.sv
// Keypad-side bundle between the keypad decoder, the lock state manager and the passcode checker.
// Latency: none, wires only.
// Backpressure: none; key strobes cannot be stalled.
interface passcode_checker_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       initialize;
    logic [2:0] state;
    logic       is_on;
    logic       is_star_pressed;
    logic       correct;
    logic [3:0] entry_len;

    // The manager and keypad side drive keys and state and consume the checker's flags.
    modport master (
        output key_valid, key_code, initialize, state,
        input  is_on, is_star_pressed, correct, entry_len
    );

    // The checker consumes keys and state and produces the flags.
    modport slave (
        input  key_valid, key_code, initialize, state,
        output is_on, is_star_pressed, correct, entry_len
    );
endinterface

// File: rtl/passcode_checker.sv
// Keypad front end: turns key events into is_on / is_star_pressed / correct and owns the passcode.
// Latency: 1 cycle; every output is registered at the edge that accepts the key.
// Backpressure: none; one key per key_valid cycle, and keys that are not meaningful in the current state are dropped.
module passcode_checker #(
    parameter int          MAX_DIGITS     = 8,
    parameter int          MIN_NEW_DIGITS = 4,
    parameter logic [15:0] DEFAULT_PW     = 16'h0000
) (
    input logic               clk,
    input logic               rst_n,
    passcode_checker_if.slave bus
);
    typedef logic [MAX_DIGITS-1:0][3:0] digits_t;

    localparam logic [3:0] MAX_LEN = 4'(MAX_DIGITS);
    localparam logic [3:0] MIN_LEN = 4'(MIN_NEW_DIGITS);

    localparam logic [2:0] ST_OFF  = 3'b000;
    localparam logic [2:0] ST_ON   = 3'b001;
    localparam logic [2:0] ST_W1   = 3'b010;
    localparam logic [2:0] ST_W2   = 3'b011;
    localparam logic [2:0] ST_ANS  = 3'b100;
    localparam logic [2:0] ST_RST  = 3'b101;
    localparam logic [2:0] ST_LOCK = 3'b111;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    // Power-up passcode: first BCD digit (bits 15:12) lands in digit slot 0.
    function automatic digits_t init_pw();
        digits_t v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            v[i] = DEFAULT_PW[15-4*i -: 4];
        end
        return v;
    endfunction

    localparam digits_t PW_INIT = init_pw();

    // Buffer matches the stored passcode when lengths agree and every stored digit agrees.
    function automatic logic pw_match(input digits_t d, input logic [3:0] len,
                                      input digits_t pw, input logic [3:0] pw_len);
        logic m;
        m = (len == pw_len);
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((4'(i) < pw_len) && (d[i] != pw[i])) begin
                m = 1'b0;
            end
        end
        return m;
    endfunction

    digits_t    entry_q;
    logic [3:0] len_q;
    digits_t    pw_q;
    logic [3:0] pw_len_q;
    logic [2:0] prev_state_q;
    logic       is_on_q;
    logic       star_q;
    logic       correct_q;

    logic       key_digit;
    logic       key_star;
    logic       key_hash;
    logic       st_check;
    logic       st_new;
    logic       st_entry;
    logic       enter_idle;
    logic       hash_toggle;
    logic       star_pulse;
    logic       star_clear;
    logic       digit_add;
    logic       commit;
    digits_t    entry_d;
    logic [3:0] len_d;
    logic       correct_d;

    // Decode the key against the manager state and build the next entry buffer and correct flag.
    always_comb begin
        key_digit   = bus.key_valid && (bus.key_code <= 4'd9);
        key_star    = bus.key_valid && (bus.key_code == KEY_STAR);
        key_hash    = bus.key_valid && (bus.key_code == KEY_HASH);
        st_check    = (bus.state == ST_ON) || (bus.state == ST_W1) || (bus.state == ST_W2);
        st_new      = (bus.state == ST_RST);
        st_entry    = st_check || st_new;
        // Entering off or lock flushes any half-typed code; only the transition counts.
        enter_idle  = (bus.state != prev_state_q) &&
                      ((bus.state == ST_OFF) || (bus.state == ST_LOCK));
        hash_toggle = key_hash && (bus.state != ST_LOCK);
        star_pulse  = key_star && (st_entry || (bus.state == ST_ANS));
        star_clear  = key_star && st_entry;
        digit_add   = key_digit && st_entry && (len_q < MAX_LEN);
        commit      = key_star && st_new && (len_q >= MIN_LEN);

        entry_d = entry_q;
        len_d   = len_q;
        if (enter_idle || hash_toggle || star_clear) begin
            len_d = 4'd0;
        end else if (digit_add) begin
            for (int i = 0; i < MAX_DIGITS; i++) begin
                if (len_q == 4'(i)) begin
                    entry_d[i] = bus.key_code;
                end
            end
            len_d = len_q + 4'd1;
        end

        // On '*' the verdict is on the buffer as it stood before the clear;
        // otherwise it tracks the buffer as it will be after this edge.
        correct_d = 1'b0;
        if (star_clear) begin
            if (st_check) begin
                correct_d = pw_match(entry_q, len_q, pw_q, pw_len_q);
            end else begin
                correct_d = (len_q >= MIN_LEN);
            end
        end else if (st_check) begin
            correct_d = pw_match(entry_d, len_d, pw_q, pw_len_q);
        end else if (st_new) begin
            correct_d = (len_d >= MIN_LEN);
        end
    end

    // Register buffer, passcode and all outputs; initialize behaves like reset and beats any key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q      <= '0;
            len_q        <= 4'd0;
            pw_q         <= PW_INIT;
            pw_len_q     <= 4'd4;
            prev_state_q <= ST_OFF;
            is_on_q      <= 1'b0;
            star_q       <= 1'b0;
            correct_q    <= 1'b0;
        end else if (bus.initialize) begin
            entry_q      <= '0;
            len_q        <= 4'd0;
            pw_q         <= PW_INIT;
            pw_len_q     <= 4'd4;
            prev_state_q <= bus.state;
            is_on_q      <= 1'b0;
            star_q       <= 1'b0;
            correct_q    <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            len_q        <= len_d;
            prev_state_q <= bus.state;
            is_on_q      <= hash_toggle ? ~is_on_q : is_on_q;
            star_q       <= star_pulse;
            correct_q    <= correct_d;
            if (commit) begin
                pw_q     <= entry_q;
                pw_len_q <= len_q;
            end
        end
    end

    assign bus.is_on           = is_on_q;
    assign bus.is_star_pressed = star_q;
    assign bus.correct         = correct_q;
    assign bus.entry_len       = len_q;
endmodule

// File: tb/tb_passcode_checker.sv
module tb_passcode_checker;
    localparam logic [2:0] S_OFF  = 3'b000;
    localparam logic [2:0] S_ON   = 3'b001;
    localparam logic [2:0] S_W1   = 3'b010;
    localparam logic [2:0] S_ANS  = 3'b100;
    localparam logic [2:0] S_RST  = 3'b101;
    localparam logic [2:0] S_LOCK = 3'b111;
    localparam logic [3:0] K_STAR = 4'hA;
    localparam logic [3:0] K_HASH = 4'hB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    passcode_checker_if bus();

    passcode_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic [2:0] st;
        logic       init;
        logic       on;
        logic       star;
        logic       corr;
        logic [3:0] len;
    } vec_t;

    typedef struct {
        int         id;
        logic       on;
        logic       star;
        logic       corr;
        logic [3:0] len;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    task automatic add(input logic kv, input logic [3:0] code, input logic [2:0] st, input logic init,
                       input logic on, input logic star, input logic corr, input logic [3:0] len);
        vec_t v;
        v.kv = kv; v.code = code; v.st = st; v.init = init;
        v.on = on; v.star = star; v.corr = corr; v.len = len;
        tbl.push_back(v);
    endtask

    task automatic compare(input exp_t e);
        checks++;
        if ({bus.is_on, bus.is_star_pressed, bus.correct, bus.entry_len} !== {e.on, e.star, e.corr, e.len}) begin
            errors++;
            $display("FAIL step %0d: got on=%0b star=%0b correct=%0b len=%0d, want on=%0b star=%0b correct=%0b len=%0d",
                     e.id, bus.is_on, bus.is_star_pressed, bus.correct, bus.entry_len,
                     e.on, e.star, e.corr, e.len);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, queue its expectation, check after the rising edge.
    task automatic step(input int id, input logic kv, input logic [3:0] code, input logic [2:0] st,
                        input logic init, input logic on, input logic star, input logic corr,
                        input logic [3:0] len);
        exp_t e;
        @(negedge clk);
        bus.key_valid  = kv;
        bus.key_code   = code;
        bus.state      = st;
        bus.initialize = init;
        e.id = id; e.on = on; e.star = star; e.corr = corr; e.len = len;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL step %0d: scoreboard empty", id);
        end else begin
            compare(sb.pop_front());
        end
    endtask

    // Asynchronous reset pulse away from any clock edge; outputs must drop before the next edge.
    task automatic async_reset(input int id);
        exp_t e;
        #2;
        bus.key_valid  = 1'b0;
        bus.initialize = 1'b0;
        rst_n = 1'b0;
        #1;
        e.id = id; e.on = 1'b0; e.star = 1'b0; e.corr = 1'b0; e.len = 4'd0;
        compare(e);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'h0;
        bus.state      = S_ON;
        bus.initialize = 1'b0;
        rst_n          = 1'b0;

        // Default passcode 0000 in ON: match coincides with the pulse, then drops.
        add(1,4'd0,S_ON,0, 0,0,0,1); add(1,4'd0,S_ON,0, 0,0,0,2);
        add(1,4'd0,S_ON,0, 0,0,0,3); add(1,4'd0,S_ON,0, 0,0,1,4);
        add(1,K_STAR,S_ON,0, 0,1,1,0); add(0,4'd0,S_ON,0, 0,0,0,0);
        // Length mismatch, then value mismatch.
        add(1,4'd1,S_ON,0, 0,0,0,1); add(1,4'd2,S_ON,0, 0,0,0,2);
        add(1,4'd3,S_ON,0, 0,0,0,3); add(1,K_STAR,S_ON,0, 0,1,0,0);
        add(0,4'd0,S_ON,0, 0,0,0,0);
        add(1,4'd0,S_ON,0, 0,0,0,1); add(1,4'd0,S_ON,0, 0,0,0,2);
        add(1,4'd0,S_ON,0, 0,0,0,3); add(1,4'd1,S_ON,0, 0,0,0,4);
        add(1,K_STAR,S_ON,0, 0,1,0,0);
        // Short new passcode in RESET is refused; old passcode still matches.
        add(0,4'd0,S_RST,0, 0,0,0,0);
        add(1,4'd9,S_RST,0, 0,0,0,1); add(1,4'd8,S_RST,0, 0,0,0,2);
        add(1,4'd7,S_RST,0, 0,0,0,3); add(1,K_STAR,S_RST,0, 0,1,0,0);
        add(0,4'd0,S_ON,0, 0,0,0,0);
        add(1,4'd0,S_ON,0, 0,0,0,1); add(1,4'd0,S_ON,0, 0,0,0,2);
        add(1,4'd0,S_ON,0, 0,0,0,3); add(1,4'd0,S_ON,0, 0,0,1,4);
        add(1,K_STAR,S_ON,0, 0,1,1,0);
        // Five-digit new passcode is committed.
        add(0,4'd0,S_RST,0, 0,0,0,0);
        add(1,4'd9,S_RST,0, 0,0,0,1); add(1,4'd8,S_RST,0, 0,0,0,2);
        add(1,4'd7,S_RST,0, 0,0,0,3); add(1,4'd6,S_RST,0, 0,0,1,4);
        add(1,4'd5,S_RST,0, 0,0,1,5); add(1,K_STAR,S_RST,0, 0,1,1,0);
        add(0,4'd0,S_ON,0, 0,0,0,0);
        add(1,4'd9,S_ON,0, 0,0,0,1); add(1,4'd8,S_ON,0, 0,0,0,2);
        add(1,4'd7,S_ON,0, 0,0,0,3); add(1,4'd6,S_ON,0, 0,0,0,4);
        add(1,4'd5,S_ON,0, 0,0,1,5); add(1,K_STAR,S_ON,0, 0,1,1,0);
        add(1,4'd0,S_ON,0, 0,0,0,1); add(1,4'd0,S_ON,0, 0,0,0,2);
        add(1,4'd0,S_ON,0, 0,0,0,3); add(1,4'd0,S_ON,0, 0,0,0,4);
        add(1,K_STAR,S_ON,0, 0,1,0,0);
        // Ten digits saturate at eight.
        for (int i = 1; i <= 10; i++) add(1,4'd1,S_ON,0, 0,0,0,(i > 8) ? 4'd8 : 4'(i));
        // '#' toggles power and clears the buffer.
        add(1,K_HASH,S_ON,0, 1,0,0,0); add(1,4'd1,S_ON,0, 1,0,0,1);
        add(1,K_HASH,S_ON,0, 0,0,0,0);
        // LOCK: entry clears the buffer, keys are dead, initialize wins over '#'.
        add(1,4'd3,S_ON,0, 0,0,0,1); add(1,K_HASH,S_ON,0, 1,0,0,0);
        add(1,4'd3,S_ON,0, 1,0,0,1); add(0,4'd0,S_LOCK,0, 1,0,0,0);
        add(1,4'd3,S_LOCK,0, 1,0,0,0); add(1,K_STAR,S_LOCK,0, 1,0,0,0);
        add(1,K_HASH,S_LOCK,0, 1,0,0,0); add(1,K_HASH,S_LOCK,1, 0,0,0,0);
        // Passcode back to 0000 after initialize.
        add(0,4'd0,S_ON,0, 0,0,0,0);
        add(1,4'd0,S_ON,0, 0,0,0,1); add(1,4'd0,S_ON,0, 0,0,0,2);
        add(1,4'd0,S_ON,0, 0,0,0,3); add(1,4'd0,S_ON,0, 0,0,1,4);
        add(1,K_STAR,S_ON,0, 0,1,1,0);
        // Codes C-F are ignored.
        add(1,4'd0,S_ON,0, 0,0,0,1); add(1,4'hC,S_ON,0, 0,0,0,1);
        add(1,4'hF,S_ON,0, 0,0,0,1); add(1,K_STAR,S_ON,0, 0,1,0,0);
        // ANSWER: '*' pulses with correct=0, digits ignored, '#' still toggles.
        add(0,4'd0,S_ANS,0, 0,0,0,0); add(1,K_STAR,S_ANS,0, 0,1,0,0);
        add(1,4'd4,S_ANS,0, 0,0,0,0); add(1,K_HASH,S_ANS,0, 1,0,0,0);
        add(1,K_HASH,S_ON,0, 0,0,0,0);
        // OFF: entry clears, digits and '*' dead, '#' toggles.
        add(1,4'd2,S_ON,0, 0,0,0,1); add(0,4'd0,S_OFF,0, 0,0,0,0);
        add(1,4'd2,S_OFF,0, 0,0,0,0); add(1,K_STAR,S_OFF,0, 0,0,0,0);
        add(1,K_HASH,S_OFF,0, 1,0,0,0); add(1,K_HASH,S_OFF,0, 0,0,0,0);
        // WRONG1 compares like ON.
        add(0,4'd0,S_W1,0, 0,0,0,0);
        add(1,4'd0,S_W1,0, 0,0,0,1); add(1,4'd0,S_W1,0, 0,0,0,2);
        add(1,4'd0,S_W1,0, 0,0,0,3); add(1,4'd0,S_W1,0, 0,0,1,4);
        add(1,K_STAR,S_W1,0, 0,1,1,0);

        // Reset state, checked asynchronously before any edge.
        #3;
        begin
            exp_t e;
            e.id = 0; e.on = 1'b0; e.star = 1'b0; e.corr = 1'b0; e.len = 4'd0;
            compare(e);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(i + 1, tbl[i].kv, tbl[i].code, tbl[i].st, tbl[i].init,
                 tbl[i].on, tbl[i].star, tbl[i].corr, tbl[i].len);
        end

        // Commit 1234, prove it took, then lose a partial entry to reset.
        step(200, 0, 4'd0, S_RST, 0, 0,0,0,0);
        step(201, 1, 4'd1, S_RST, 0, 0,0,0,1);
        step(202, 1, 4'd2, S_RST, 0, 0,0,0,2);
        step(203, 1, 4'd3, S_RST, 0, 0,0,0,3);
        step(204, 1, 4'd4, S_RST, 0, 0,0,1,4);
        step(205, 1, K_STAR, S_RST, 0, 0,1,1,0);
        step(206, 0, 4'd0, S_ON, 0, 0,0,0,0);
        step(207, 1, 4'd1, S_ON, 0, 0,0,0,1);
        step(208, 1, 4'd2, S_ON, 0, 0,0,0,2);
        step(209, 1, 4'd3, S_ON, 0, 0,0,0,3);
        step(210, 1, 4'd4, S_ON, 0, 0,0,1,4);
        step(211, 1, K_STAR, S_ON, 0, 0,1,1,0);
        step(212, 0, 4'd0, S_RST, 0, 0,0,0,0);
        step(213, 1, 4'd5, S_RST, 0, 0,0,0,1);
        step(214, 1, 4'd6, S_RST, 0, 0,0,0,2);
        step(215, 1, 4'd7, S_RST, 0, 0,0,0,3);
        async_reset(216);

        // Passcode is DEFAULT_PW again; then reset in the middle of the '*' pulse.
        step(220, 0, 4'd0, S_ON, 0, 0,0,0,0);
        step(221, 1, 4'd0, S_ON, 0, 0,0,0,1);
        step(222, 1, 4'd0, S_ON, 0, 0,0,0,2);
        step(223, 1, 4'd0, S_ON, 0, 0,0,0,3);
        step(224, 1, 4'd0, S_ON, 0, 0,0,1,4);
        step(225, 1, K_STAR, S_ON, 0, 0,1,1,0);
        async_reset(226);
        step(227, 0, 4'd0, S_ON, 0, 0,0,0,0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
